remote_input_decoder: RTL and testbench
=======================================

Name: remote_input_decoder

Overview:
- Receive-side counterpart of the remote turn/throw link.
- Takes bytes from the board UART receiver and decodes 3-byte command frames sent by the remote board.
- Reconstructs the remote player's `space` key level and `cat_turn` ownership flag, which feed the turn FSM.
- A link watchdog forces `space` low if the remote board goes silent.

Parameters:
- TIMEOUT_CYCLES, 65000000, cycles without a valid frame before the link is declared dead (1 s at 65 MHz).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock (65 MHz)
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte from the UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data is valid while high
- space  output  1  decoded remote space-key level
- cat_turn  output  1  decoded remote turn-ownership flag
- frame_ok  output  1  one-cycle pulse per accepted frame
- frame_err  output  1  one-cycle pulse per rejected frame
- link_alive  output  1  high while valid frames arrive within TIMEOUT_CYCLES

Behaviour:
- Frame format: byte0 = SYNC_BYTE; byte1 = CMD; byte2 = CHK.
  - CMD[0] is space, CMD[1] is cat_turn, CMD[7:2] are reserved and must be 0.
  - CHK must equal ~CMD.
- Reset: all outputs 0, FSM in WAIT_SYNC, cmd register 0, watchdog counter 0. Reset may assert at any time and aborts any partial frame.
- Only cycles with rx_valid=1 advance the FSM. Bytes are consumed one per strobe, and there are no back-to-back restrictions.
- FSM transitions:
  - WAIT_SYNC: if byte == SYNC_BYTE, go to WAIT_CMD; otherwise stay. Discarded bytes do not raise frame_err.
  - WAIT_CMD: latch the byte as cmd and go to WAIT_CHK. Any value is accepted here, including SYNC_BYTE.
  - WAIT_CHK, byte == ~cmd and cmd[7:2] == 0: accept the frame and go to WAIT_SYNC.
  - WAIT_CHK, otherwise: reject the frame and pulse frame_err. If the byte == SYNC_BYTE, go to WAIT_CMD (resync); otherwise go to WAIT_SYNC.
- On accept, the following are all registered and visible the cycle after the CHK strobe:
  - space <= cmd[0]
  - cat_turn <= cmd[1]
  - frame_ok = 1 for exactly one cycle
  - link_alive <= 1
  - watchdog counter <= 0
- A rejected frame leaves space and cat_turn unchanged.
- Watchdog behaviour:
  - While link_alive=1, the counter increments every cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no accept that cycle: link_alive <= 0, space <= 0, counter <= 0. cat_turn keeps its last value.
  - While link_alive=0, the counter is held at 0.
  - If an accept and expiry occur in the same cycle, the accept wins: link_alive stays 1 and the counter is cleared.
- Counter width: 32 bits. TIMEOUT_CYCLES must be ≥ 2.
- frame_ok and frame_err are never high in the same cycle.

Optional Feature:
- Macro: REMOTE_ERR_CNT_EN.
- When defined, add the output port err_count (8 bits):
  - Increments on every frame_err pulse.
  - Saturates at 255.
  - Cleared by rst only.
- When undefined, the port and its counter are absent and all other behaviour is identical.

Test Plan:
- Reset, then stream A5,03,FC → one cycle after the FC strobe: space=1, cat_turn=1, frame_ok pulses once, link_alive=1.
- Stream A5,01,FE, then A5,00,FF → after the first frame space=1, cat_turn=0; after the second space=0. No frame_err.
- Stream A5,03,00 (bad CHK), then A5,02,FD → frame_err pulses once and space/cat_turn keep their prior values; the second frame is accepted with cat_turn=1, space=0. With REMOTE_ERR_CNT_EN, err_count=1.
- Stream A5,07,F8 (reserved bit set) → frame_err pulses and outputs are unchanged.
- Stream A5,03,A5,01,FE (SYNC in the CHK slot) → first frame rejected, resync via the CHK-slot A5, and 01,FE is accepted: space=1, cat_turn=0.
- With TIMEOUT_CYCLES=100: accept A5,03,FC, then stay idle → exactly 100 cycles after the frame_ok cycle, link_alive=0, space=0, cat_turn=1. A new valid frame restores link_alive=1.

Source files
------------

// File: rtl/remote_input_decoder.sv
// rtl/remote_input_decoder.sv - decodes remote turn/throw command frames from UART bytes
//
// Purpose:
//   Receives bytes from the board UART receiver and parses 3-byte frames
//   {SYNC_BYTE, CMD, CHK}. It rebuilds the remote player's space-key level
//   and cat_turn ownership flag. A link watchdog drops space when frames
//   stop arriving.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rx_data    in   [7:0] received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   space      out  decoded remote space-key level
//   cat_turn   out  decoded remote turn-ownership flag
//   frame_ok   out  one-cycle pulse per accepted frame
//   frame_err  out  one-cycle pulse per rejected frame
//   link_alive out  high while valid frames arrive within TIMEOUT_CYCLES
//   err_count  out  [7:0] saturating rejected-frame count (REMOTE_ERR_CNT_EN only)
//
// Build option:
//   REMOTE_ERR_CNT_EN adds the err_count port and its counter.

module remote_input_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 65000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       space,
    output logic       cat_turn,
    output logic       frame_ok,
    output logic       frame_err,
`ifdef REMOTE_ERR_CNT_EN
    output logic [7:0] err_count,
`endif
    output logic       link_alive
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        WAIT_CMD  = 2'd1,
        WAIT_CHK  = 2'd2
    } state_t;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cmd;
    logic [31:0] wd_count;

    // The checksum slot is the only place a frame is judged. The reserved
    // CMD bits are part of the check, so a frame with a good inverse but a
    // reserved bit set is still rejected.
    logic chk_strobe;
    logic chk_good;
    logic accept;
    logic reject;

    always_comb begin
        chk_strobe = rx_valid && (state == WAIT_CHK);
        chk_good   = (rx_data == ~cmd) && (cmd[7:2] == 6'd0);
        accept     = chk_strobe && chk_good;
        reject     = chk_strobe && !chk_good;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_SYNC;
            cmd        <= 8'd0;
            wd_count   <= 32'd0;
            space      <= 1'b0;
            cat_turn   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            link_alive <= 1'b0;
        end else begin
            frame_ok  <= accept;
            frame_err <= reject;

            if (rx_valid) begin
                case (state)
                    WAIT_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= WAIT_CMD;
                        end
                    end
                    WAIT_CMD: begin
                        // Any value is a legal command byte, including SYNC_BYTE.
                        cmd   <= rx_data;
                        state <= WAIT_CHK;
                    end
                    WAIT_CHK: begin
                        // A sync byte in the checksum slot of a failed
                        // frame starts the next frame, so resync there.
                        if (!chk_good && (rx_data == SYNC_BYTE)) begin
                            state <= WAIT_CMD;
                        end else begin
                            state <= WAIT_SYNC;
                        end
                    end
                    default: begin
                        state <= WAIT_SYNC;
                    end
                endcase
            end

            // An accept takes priority over a watchdog expiry that falls
            // in the same cycle.
            if (accept) begin
                space      <= cmd[0];
                cat_turn   <= cmd[1];
                link_alive <= 1'b1;
                wd_count   <= 32'd0;
            end else if (link_alive) begin
                if (wd_count == WD_LAST) begin
                    // On link loss only the key is released; turn ownership
                    // keeps its last known value.
                    link_alive <= 1'b0;
                    space      <= 1'b0;
                    wd_count   <= 32'd0;
                end else begin
                    wd_count <= wd_count + 32'd1;
                end
            end else begin
                wd_count <= 32'd0;
            end
        end
    end

`ifdef REMOTE_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (frame_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_remote_input_decoder.sv
// tb/tb_remote_input_decoder.sv - scoreboard bench for remote_input_decoder
module tb_remote_input_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       space;
    logic       cat_turn;
    logic       frame_ok;
    logic       frame_err;
    logic       link_alive;
`ifdef REMOTE_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    remote_input_decoder #(
        .TIMEOUT_CYCLES(100),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .space     (space),
        .cat_turn  (cat_turn),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
`ifdef REMOTE_ERR_CNT_EN
        .err_count (err_count),
`endif
        .link_alive(link_alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response: {is_ok, space, cat_turn, link_alive}
    typedef struct packed {
        logic ok;
        logic sp;
        logic ct;
        logic la;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation for every frame_ok/frame_err pulse.
    always @(negedge clk) begin
        if (!rst && (frame_ok || frame_err)) begin
            check("pulse_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {31'd0, frame_ok}, 32'd2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_ok}, {31'd0, e.ok});
                check("space",      {31'd0, space},      {31'd0, e.sp});
                check("cat_turn",   {31'd0, cat_turn},   {31'd0, e.ct});
                check("link_alive", {31'd0, link_alive}, {31'd0, e.la});
            end
        end
    end

    // Called at #1 after a posedge; consecutive calls give back-to-back strobes.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input logic ok, input logic sp, input logic ct, input logic la);
        exp_t e;
        e.ok = ok; e.sp = sp; e.ct = ct; e.la = la;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag, input logic sp, input logic ct, input logic la);
        check({tag, "_space"},      {31'd0, space},      {31'd0, sp});
        check({tag, "_cat_turn"},   {31'd0, cat_turn},   {31'd0, ct});
        check({tag, "_link_alive"}, {31'd0, link_alive}, {31'd0, la});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);

        check_idle_outputs("reset", 1'b0, 1'b0, 1'b0);
        check("reset_frame_ok",  {31'd0, frame_ok},  32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);

        // Noise before sync is silently discarded.
        send_byte(8'h12);
        send_byte(8'hFC);

        expect_pulse(1'b1, 1'b1, 1'b1, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'hFC);
        idle(2);

        expect_pulse(1'b1, 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFE);
        idle(1);
        expect_pulse(1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF);
        idle(2);

        // Bad checksum keeps outputs; next frame is accepted.
        expect_pulse(1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
        expect_pulse(1'b1, 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hFD);
        idle(2);

        // Reserved bit set with a correct inverse is still rejected.
        expect_pulse(1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'hF8);
        idle(2);

        // SYNC in the checksum slot rejects and resyncs.
        expect_pulse(1'b0, 1'b0, 1'b1, 1'b1);
        expect_pulse(1'b1, 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'hFE);
        idle(2);

        // SYNC_BYTE is a legal CMD value (reserved bits set, so rejected at CHK).
        expect_pulse(1'b0, 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h5A);
        idle(2);

`ifdef REMOTE_ERR_CNT_EN
        check("err_count", {24'd0, err_count}, 32'd4);
`endif

        // Watchdog: after the CHK edge, link drops exactly at the 100th edge.
        expect_pulse(1'b1, 1'b1, 1'b1, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'hFC);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 99) check_idle_outputs("wd_edge99", 1'b1, 1'b1, 1'b1);
            if (i == 100) check_idle_outputs("wd_expired", 1'b0, 1'b1, 1'b0);
        end
        idle(5);
        check_idle_outputs("wd_held", 1'b0, 1'b1, 1'b0);

        expect_pulse(1'b1, 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFE);
        idle(2);
        check_idle_outputs("wd_restored", 1'b1, 1'b0, 1'b1);

        // Reset mid-frame aborts the partial frame; the FC is then noise.
        send_byte(8'hA5); send_byte(8'h03);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check_idle_outputs("midreset", 1'b0, 1'b0, 1'b0);
`ifdef REMOTE_ERR_CNT_EN
        check("err_count_reset", {24'd0, err_count}, 32'd0);
`endif
        send_byte(8'hFC);
        idle(2);
        expect_pulse(1'b1, 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hFD);
        idle(4);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
